// File: rtl/biu_constants_pkg.sv
// BIU transfer encodings shared by initiators and targets, plus the burst
// helpers both sides need to agree on:
//   biu_type2beats : number of beats a burst type carries
//   biu_nxt_adr    : byte address of the following beat (INCR linear, WRAP
//                    wrapping inside a beats*size aligned window)
package biu_constants_pkg;

  typedef enum logic [2:0] {
    BYTE  = 3'b000,
    HWORD = 3'b001,
    WORD  = 3'b010,
    DWORD = 3'b011,
    QWORD = 3'b100
  } biu_size_t;

  typedef enum logic [2:0] {
    SINGLE = 3'b000,
    INCR   = 3'b001,
    WRAP4  = 3'b010,
    INCR4  = 3'b011,
    WRAP8  = 3'b100,
    INCR8  = 3'b101,
    WRAP16 = 3'b110,
    INCR16 = 3'b111
  } biu_type_t;

  typedef logic [2:0] biu_prot_t;

  // Helpers work on the widest supported address; callers cast in and out.
  localparam int BIU_ADR_W = 64;

  function automatic logic [4:0] biu_type2beats(input biu_type_t btype);
    case (btype)
      WRAP4, INCR4:   return 5'd4;
      WRAP8, INCR8:   return 5'd8;
      WRAP16, INCR16: return 5'd16;
      default:        return 5'd1;
    endcase
  endfunction

  function automatic logic [BIU_ADR_W-1:0] biu_nxt_adr(input logic [BIU_ADR_W-1:0] adr,
                                                       input biu_size_t            size,
                                                       input biu_type_t            btype);
    logic [BIU_ADR_W-1:0] incr;
    logic [BIU_ADR_W-1:0] mask;
    incr = BIU_ADR_W'(1) << size;
    mask = (BIU_ADR_W'(biu_type2beats(btype)) * incr) - BIU_ADR_W'(1);
    case (btype)
      WRAP4, WRAP8, WRAP16: return (adr & ~mask) | ((adr + incr) & mask);
      default:              return adr + incr;
    endcase
  endfunction

endpackage

// File: rtl/riscv_dtcm_ram.sv
// Single-port data RAM with per-byte write enables and a registered read.
// Kept behavioural so it maps onto a technology SRAM macro.
//   clk_i  : clock
//   en_i   : port enable (read and/or write this cycle)
//   we_i   : write enable, qualified per byte by be_i
//   be_i   : byte enables
//   adr_i  : word address
//   d_i    : write data
//   q_o    : read data, valid the cycle after an enabled access
module riscv_dtcm_ram #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 1024
) (
  input  logic                     clk_i,
  input  logic                     en_i,
  input  logic                     we_i,
  input  logic [XLEN/8-1:0]        be_i,
  input  logic [$clog2(DEPTH)-1:0] adr_i,
  input  logic [XLEN-1:0]          d_i,
  output logic [XLEN-1:0]          q_o
);

  logic [XLEN-1:0] r_mem [DEPTH];
  logic [XLEN-1:0] r_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int i = 0; i < XLEN/8; i++) begin
          if (be_i[i]) r_mem[adr_i][8*i +: 8] <= d_i[8*i +: 8];
        end
      end
      r_q <= r_mem[adr_i];
    end
  end

  assign q_o = r_q;

endmodule

// File: rtl/riscv_biu_dtcm_responder.sv
// BIU target backed by a local word-addressed data memory (DTCM).
// Serves SINGLE and fixed-length INCR/WRAP bursts of byte/halfword/word
// beats, with WAIT_STATES idle cycles ahead of every beat.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   biu_stb_i / _stb_ack_o: request strobe / request accepted (IDLE only)
//   biu_adri_i, _size_i, _type_i, _we_i : request attributes, latched on accept
//   biu_lock_i, _prot_i   : accepted, not used
//   biu_d_i / biu_d_ack_o : write data / data of current beat consumed
//   biu_q_o, biu_adro_o   : read data and beat address, valid with ack/err
//   biu_ack_o / biu_err_o : beat completed OK / with error
// A beat is "issued" in the cycle the RAM is accessed; its ack/err appears
// the following cycle, overlapping the issue of the next beat.
module riscv_biu_dtcm_responder
  import biu_constants_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              PLEN        = XLEN,
  parameter logic [PLEN-1:0] BASE        = '0,
  parameter int              DEPTH       = 1024,
  parameter int              WAIT_STATES = 0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            biu_stb_i,
  output logic            biu_stb_ack_o,
  output logic            biu_d_ack_o,
  input  logic [PLEN-1:0] biu_adri_i,
  output logic [PLEN-1:0] biu_adro_o,
  input  biu_size_t       biu_size_i,
  input  biu_type_t       biu_type_i,
  input  logic            biu_we_i,
  input  logic            biu_lock_i,
  input  biu_prot_t       biu_prot_i,
  input  logic [XLEN-1:0] biu_d_i,
  output logic [XLEN-1:0] biu_q_o,
  output logic            biu_ack_o,
  output logic            biu_err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = XLEN / 8;

  typedef enum logic [1:0] {IDLE, WAIT, RD, WR} state_t;

  state_t          r_state, w_nxt_state;
  logic [4:0]      r_beats;
  logic [2:0]      r_wcnt;
  logic [PLEN-1:0] r_nadr, r_radr;
  logic            r_rerr, r_we;
  biu_size_t       r_size;
  biu_type_t       r_type;

  logic            w_issue, w_iss_we, w_iss_err, w_misal;
  logic [PLEN-1:0] w_iss_adr, w_off, w_nxt_adr;
  biu_size_t       w_iss_size;
  biu_type_t       w_iss_type;
  logic [4:0]      w_iss_beats;
  logic [BW-1:0]   w_be;
  logic [XLEN-1:0] w_ram_q;
  logic            w_unused;

  assign w_unused = ^{biu_lock_i, biu_prot_i};

  // Beat 0 of a zero-wait transfer issues in the accept cycle, so the
  // live request feeds the issue path while IDLE.
  always_comb begin
    if (r_state == IDLE) begin
      w_iss_adr   = biu_adri_i;
      w_iss_size  = biu_size_i;
      w_iss_type  = biu_type_i;
      w_iss_we    = biu_we_i;
      w_iss_beats = biu_type2beats(biu_type_i);
    end else begin
      w_iss_adr   = r_nadr;
      w_iss_size  = r_size;
      w_iss_type  = r_type;
      w_iss_we    = r_we;
      w_iss_beats = r_beats;
    end
  end

  // Addresses below BASE wrap to a huge offset and fail the range test too.
  assign w_off     = w_iss_adr - BASE;
  assign w_nxt_adr = PLEN'(biu_nxt_adr(BIU_ADR_W'(w_iss_adr), w_iss_size, w_iss_type));

  always_comb begin
    case (w_iss_size)
      BYTE:    w_misal = 1'b0;
      HWORD:   w_misal = w_iss_adr[0];
      WORD:    w_misal = |w_iss_adr[1:0];
      default: w_misal = 1'b1;
    endcase
  end

  assign w_iss_err = w_misal | (|(w_off >> (AW + 2)));

  always_comb begin
    case (w_iss_size)
      BYTE:    w_be = BW'(1) << w_iss_adr[1:0];
      HWORD:   w_be = BW'(3) << {w_iss_adr[1], 1'b0};
      default: w_be = '1;
    endcase
  end

  // Reset gates every output so an aborted burst shows nothing further.
  always_comb begin
    w_nxt_state   = r_state;
    w_issue       = 1'b0;
    biu_stb_ack_o = 1'b0;
    biu_d_ack_o   = 1'b0;
    biu_ack_o     = 1'b0;
    biu_err_o     = 1'b0;
    biu_q_o       = '0;
    biu_adro_o    = '0;
    if (!rst_i) begin
      case (r_state)
        IDLE: begin
          biu_stb_ack_o = biu_stb_i;
          if (biu_stb_i) begin
            if (WAIT_STATES == 0) begin
              w_issue     = 1'b1;
              w_nxt_state = biu_we_i ? WR : RD;
            end else begin
              w_nxt_state = WAIT;
            end
          end
        end
        WAIT: begin
          if (r_wcnt == 3'd0) begin
            w_issue     = 1'b1;
            w_nxt_state = r_we ? WR : RD;
          end
        end
        default: begin
          biu_ack_o  = ~r_rerr;
          biu_err_o  = r_rerr;
          biu_adro_o = r_radr;
          if (r_state == RD && !r_rerr) biu_q_o = w_ram_q;
          if (r_beats != 5'd0) begin
            if (WAIT_STATES == 0) w_issue     = 1'b1;
            else                  w_nxt_state = WAIT;
          end else begin
            w_nxt_state = IDLE;
          end
        end
      endcase
      biu_d_ack_o = w_issue & w_iss_we;
    end
  end

  // The accept cycle counts as the first idle cycle, so WAIT reloads with
  // WAIT_STATES-1 and issues the beat when the count reaches zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_beats <= '0;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_wcnt  <= (r_state == WAIT) ? r_wcnt - 3'd1 : 3'(WAIT_STATES - 1);
      if (w_issue)            r_beats <= w_iss_beats - 5'd1;
      else if (biu_stb_ack_o) r_beats <= w_iss_beats;
    end
  end

  always_ff @(posedge clk_i) begin
    if (biu_stb_ack_o) begin
      r_size <= biu_size_i;
      r_type <= biu_type_i;
      r_we   <= biu_we_i;
      r_nadr <= biu_adri_i;
    end
    if (w_issue) begin
      r_nadr <= w_nxt_adr;
      r_radr <= w_iss_adr;
      r_rerr <= w_iss_err;
    end
  end

  // Issue stage -> response stage boundary is the RAM read register.
  riscv_dtcm_ram #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i (clk_i),
    .en_i  (w_issue),
    .we_i  (w_issue & w_iss_we & ~w_iss_err),
    .be_i  (w_be),
    .adr_i (w_off[AW+1:2]),
    .d_i   (biu_d_i),
    .q_o   (w_ram_q)
  );

endmodule
